// File: rtl/watch_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : watch_set_ctrl
// Brief    : Mode/set sequencer for the watch: run gating, field select,
//            adjust strobes and field blink. Macro WATCH_CTRL_AUTO_EXIT_EN
//            enables the idle timeout back to NORMAL.
// Revision : 1.0  initial release
// ============================================================================
module watch_set_ctrl #(
    parameter int TIMEOUT    = 60,
    parameter int BLINK_HALF = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_pulse,
    input  logic       adjust_pulse,
    output logic       run_en,
    output logic [1:0] field_sel,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink
);

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam logic [7:0] c_blink_term = 8'(BLINK_HALF - 1);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range_err
        $error("watch_set_ctrl: TIMEOUT out of range 2..65535");
    end
    if (BLINK_HALF < 1 || BLINK_HALF > 255) begin : g_blink_range_err
        $error("watch_set_ctrl: BLINK_HALF out of range 1..255");
    end

    state_t     r_state;
    logic [7:0] r_blink_cnt;
    logic       r_run_en;
    logic       r_inc_hour;
    logic       r_inc_min;
    logic       r_clr_sec;
    logic       r_blink;
    logic       w_timeout;
    state_t     w_next_mode;

    // State encoding doubles as the field select code.
    assign w_next_mode = state_t'(r_state + 2'd1);

`ifdef WATCH_CTRL_AUTO_EXIT_EN
    localparam logic [15:0] c_idle_term = 16'(TIMEOUT - 1);
    logic [15:0] r_idle_cnt;

    // A pulse in the terminal cycle outranks the timeout (handled by priority below).
    assign w_timeout = (r_state != NORMAL) && (r_idle_cnt == c_idle_term);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idle_cnt <= 16'd0;
        end else if (mode_pulse || adjust_pulse || w_timeout || r_state == NORMAL) begin
            r_idle_cnt <= 16'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= NORMAL;
            r_run_en    <= 1'b1;
            r_inc_hour  <= 1'b0;
            r_inc_min   <= 1'b0;
            r_clr_sec   <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_cnt <= 8'd0;
        end else begin
            r_inc_hour <= 1'b0;
            r_inc_min  <= 1'b0;
            r_clr_sec  <= 1'b0;
            if (mode_pulse) begin
                r_state     <= w_next_mode;
                r_run_en    <= (w_next_mode == NORMAL);
                r_blink     <= (w_next_mode != NORMAL);
                r_blink_cnt <= 8'd0;
            end else if (r_state != NORMAL) begin
                if (adjust_pulse) begin
                    case (r_state)
                        SET_HOUR: r_inc_hour <= 1'b1;
                        SET_MIN:  r_inc_min  <= 1'b1;
                        default:  r_clr_sec  <= 1'b1;
                    endcase
                    r_blink     <= 1'b1;
                    r_blink_cnt <= 8'd0;
                end else if (w_timeout) begin
                    r_state     <= NORMAL;
                    r_run_en    <= 1'b1;
                    r_blink     <= 1'b0;
                    r_blink_cnt <= 8'd0;
                end else if (r_blink_cnt == c_blink_term) begin
                    r_blink     <= ~r_blink;
                    r_blink_cnt <= 8'd0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    assign run_en    = r_run_en;
    assign field_sel = r_state;
    assign inc_hour  = r_inc_hour;
    assign inc_min   = r_inc_min;
    assign clr_sec   = r_clr_sec;
    assign blink     = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_watch_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_set_ctrl
// Brief    : Scoreboard bench for watch_set_ctrl (TIMEOUT=8, BLINK_HALF=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_watch_set_ctrl;

    localparam int TIMEOUT    = 8;
    localparam int BLINK_HALF = 2;
`ifdef WATCH_CTRL_AUTO_EXIT_EN
    localparam bit AUTO_EXIT = 1'b1;
`else
    localparam bit AUTO_EXIT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       mode_pulse;
    logic       adjust_pulse;
    logic       run_en;
    logic [1:0] field_sel;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic       blink;

    watch_set_ctrl #(
        .TIMEOUT    (TIMEOUT),
        .BLINK_HALF (BLINK_HALF)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .mode_pulse   (mode_pulse),
        .adjust_pulse (adjust_pulse),
        .run_en       (run_en),
        .field_sel    (field_sel),
        .inc_hour     (inc_hour),
        .inc_min      (inc_min),
        .clr_sec      (clr_sec),
        .blink        (blink)
    );

    initial forever #5 clock = ~clock;

    // Expected {run_en, field_sel, inc_hour, inc_min, clr_sec, blink} per edge.
    logic [6:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit done   = 1'b0;

    // Reference model: field index, idle cycles since activity, cycles since blink restart.
    int m_field = 0;
    int m_idle  = 0;
    int m_since = 0;

    task automatic drive(input logic r, input logic m, input logic a);
        logic h, mi, s, b, re;
        reset        = r;
        mode_pulse   = m;
        adjust_pulse = a;
        h = 1'b0; mi = 1'b0; s = 1'b0;
        if (!r) begin
            m_field = 0; m_idle = 0; m_since = 0;
        end else if (m) begin
            m_field = (m_field + 1) % 4; m_idle = 0; m_since = 0;
        end else if (m_field != 0) begin
            if (a) begin
                h  = (m_field == 1);
                mi = (m_field == 2);
                s  = (m_field == 3);
                m_idle = 0; m_since = 0;
            end else begin
                m_idle++;
                m_since++;
                if (AUTO_EXIT && m_idle == TIMEOUT) m_field = 0;
            end
        end
        re = (m_field == 0);
        b  = (m_field != 0) && (((m_since / BLINK_HALF) % 2) == 0);
        exp_q.push_back({re, 2'(m_field), h, mi, s, b});
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every edge presents a full output set; compare against the queue head.
    initial begin : monitor
        logic [6:0] got;
        logic [6:0] exp;
        forever begin
            @(posedge clock);
            #1;
            if (done) break;
            cyc++;
            got = {run_en, field_sel, inc_hour, inc_min, clr_sec, blink};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty cycle %0d got %b required an expected entry", cyc, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outputs cycle %0d got %b required %b (run_en,field_sel,inc_hour,inc_min,clr_sec,blink)",
                             cyc, got, exp);
                end
            end
        end
    end

    initial begin : driver
        // Reset hold, then adjust in NORMAL must be ignored.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b1);
        idle(2);

        // Full mode cycle, pulses three apart.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            idle(2);
        end

        // SET_MIN: three back-to-back adjusts, then let blink run.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
        idle(6);

        // Mode and adjust together in SET_HOUR.
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b1);
        idle(3);

        // SET_SEC left idle: timeout or persistence.
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        idle(100);

        // Reset while an inc_hour strobe is high.
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        idle(2);

        // Pulse in the terminal idle cycle, then random traffic.
        drive(1'b1, 1'b1, 1'b0);
        idle(TIMEOUT - 1);
        drive(1'b1, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) == 0));
        end
        idle(2);

        done = 1'b1;
        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
